// File: rtl/wb_mux_tmo.sv
// Wishbone classic 1-master / N-slave decoder-mux with a per-transfer slave
// watchdog, an error response for unmapped addresses, an optional registered
// response stage and a slave select that is locked for the whole cyc period.
//
// Handshake: a master transfer is requested with wbm_cyc_i & wbm_stb_i and is
// completed by exactly one cycle of wbm_ack_o, wbm_err_o or wbm_rty_o; the
// master must keep adr/dat/sel/we stable while stb is high and no response has
// been seen. Toward the slaves, the selected slave sees the same
// cyc/stb semantics and completes with its own ack/err/rty.
module wb_mux_tmo #(
  parameter int                       NUM_SLAVES = 10,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
  parameter int                       TIMEOUT    = 255,
  parameter bit                       REG_RESP   = 1'b0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n_i,
  // master side
  input  logic [AW-1:0]                wbm_adr_i,
  input  logic [DW-1:0]                wbm_dat_i,
  input  logic [DW/8-1:0]              wbm_sel_i,
  input  logic                         wbm_we_i,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  input  logic [2:0]                   wbm_cti_i,
  input  logic [1:0]                   wbm_bte_i,
  output logic [DW-1:0]                wbm_dat_o,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic                         wbm_rty_o,
  // slave side
  output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o,
  output logic [NUM_SLAVES-1:0]        wbs_we_o,
  output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
  input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]        wbs_err_i,
  input  logic [NUM_SLAVES-1:0]        wbs_rty_i,
  // watchdog status
  output logic                         tmo_o,
  output logic [3:0]                   tmo_slave_o,
  // debug view of the FSM state
  output logic [2:0]                   dbg_state_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_RESP   = 3'd2,
    S_ERR    = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_sel;
  logic [WW-1:0]           r_wdog;
  logic [DW-1:0]           r_rdat;
  logic                    r_rack;
  logic                    r_rerr;
  logic                    r_rrty;
  logic [3:0]              r_tmo_slave;

  logic                    w_hit;
  logic [3:0]              w_hit_idx;
  logic [NUM_SLAVES-1:0]   w_sel_oh;
  logic [DW-1:0]           w_s_dat;
  logic                    w_s_ack;
  logic                    w_s_err;
  logic                    w_s_rty;
  logic                    w_s_resp;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        w_hit     = 1'b1;
        w_hit_idx = 4'(i);
      end
    end
  end

  // Pick out the locked slave's response; responses of other slaves are ignored.
  always_comb begin
    w_sel_oh = '0;
    w_s_dat  = '0;
    w_s_ack  = 1'b0;
    w_s_err  = 1'b0;
    w_s_rty  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == 4'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_s_dat     = wbs_dat_i[i*DW +: DW];
        w_s_ack     = wbs_ack_i[i];
        w_s_err     = wbs_err_i[i];
        w_s_rty     = wbs_rty_i[i];
      end
    end
  end

  assign w_s_resp = w_s_ack | w_s_err | w_s_rty;

  // Request fields go to every slave; only cyc/stb are steered.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  // Main FSM: select lock, watchdog, response capture and abort bookkeeping.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_wdog      <= '0;
      r_rdat      <= '0;
      r_rack      <= 1'b0;
      r_rerr      <= 1'b0;
      r_rrty      <= 1'b0;
      r_tmo_slave <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (wbm_cyc_i && wbm_stb_i) begin
            r_sel   <= w_hit_idx;
            r_state <= w_hit ? S_ACTIVE : S_ERR;
          end
        end
        S_ACTIVE: begin
          if (!wbm_cyc_i) begin
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else if (w_s_resp) begin
            // A response in the last watchdog cycle still wins over the abort.
            r_wdog <= '0;
            if (REG_RESP) begin
              r_rdat  <= w_s_dat;
              r_rack  <= w_s_ack;
              r_rerr  <= w_s_err;
              r_rrty  <= w_s_rty;
              r_state <= S_RESP;
            end
          end else if (wbm_stb_i) begin
            if (r_wdog == WDOG_LAST) begin
              r_wdog      <= '0;
              r_tmo_slave <= r_sel;
              r_state     <= S_ABORT;
            end else begin
              r_wdog <= r_wdog + WW'(1);
            end
          end else begin
            r_wdog <= '0;
          end
        end
        S_RESP: begin
          r_rack  <= 1'b0;
          r_rerr  <= 1'b0;
          r_rrty  <= 1'b0;
          r_state <= wbm_cyc_i ? S_ACTIVE : S_IDLE;
        end
        S_ERR:   r_state <= S_IDLE;
        S_ABORT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slave cyc follows the master while a slave is locked; stb is held off in RESP.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (r_state == S_ACTIVE || r_state == S_RESP) begin
      wbs_cyc_o = w_sel_oh & {NUM_SLAVES{wbm_cyc_i}};
    end
    if (r_state == S_ACTIVE) begin
      wbs_stb_o = w_sel_oh & {NUM_SLAVES{wbm_stb_i}};
    end
  end

  // Master response: pass-through, registered copy, or locally generated error.
  always_comb begin
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        if (!REG_RESP && wbm_cyc_i) begin
          wbm_dat_o = w_s_dat;
          wbm_ack_o = w_s_ack;
          wbm_err_o = w_s_err;
          wbm_rty_o = w_s_rty;
        end
      end
      S_RESP: begin
        // A master that has already dropped cyc no longer wants the response.
        if (wbm_cyc_i) begin
          wbm_dat_o = r_rdat;
          wbm_ack_o = r_rack;
          wbm_err_o = r_rerr;
          wbm_rty_o = r_rrty;
        end
      end
      S_ERR:   wbm_err_o = 1'b1;
      S_ABORT: wbm_err_o = 1'b1;
      default: ;
    endcase
  end

  assign tmo_o       = (r_state == S_ABORT);
  assign tmo_slave_o = r_tmo_slave;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_mux_tmo.sv
// Bench for wb_mux_tmo: one instance with pass-through responses and one with
// the registered response stage, each driven by its own master and a bank of
// simple programmable-latency slave models.
module tb_wb_mux_tmo;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 16;

  // slave 1: 0x1100-0x11FF, slave 2: 0x1000-0x1FFF (overlap -> slave 1 wins)
  localparam logic [NS*AW-1:0] M_ADDR = {32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000,
                                         32'h0000_2000, 32'h0000_1000, 32'h0000_1100, 32'h0000_0000};
  localparam logic [NS*AW-1:0] M_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
                                         32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_F000};

  localparam logic [1:0] K_ACK = 2'b01;
  localparam logic [1:0] K_ERR = 2'b10;
  localparam logic [1:0] K_RTY = 2'b11;

  logic clk;
  logic rst_n;

  logic [AW-1:0]     m_adr [2];
  logic [DW-1:0]     m_dat [2];
  logic [DW/8-1:0]   m_sel [2];
  logic              m_we  [2];
  logic              m_cyc [2];
  logic              m_stb [2];
  logic [2:0]        m_cti [2];
  logic [1:0]        m_bte [2];
  logic [DW-1:0]     mo_dat [2];
  logic              mo_ack [2];
  logic              mo_err [2];
  logic              mo_rty [2];
  logic [NS*AW-1:0]  sb_adr [2];
  logic [NS*DW-1:0]  sb_dat [2];
  logic [NS*4-1:0]   sb_sel [2];
  logic [NS-1:0]     sb_we  [2];
  logic [NS*3-1:0]   sb_cti [2];
  logic [NS*2-1:0]   sb_bte [2];
  logic [NS-1:0]     sc_cyc [2];
  logic [NS-1:0]     sc_stb [2];
  logic              tmo    [2];
  logic [3:0]        tmo_sl [2];
  logic [2:0]        dbg    [2];

  // slave models
  logic [NS-1:0]     s_ack_r [2];
  logic [NS-1:0]     s_err_r [2];
  logic [NS-1:0]     s_rty_r [2];
  logic [NS*DW-1:0]  s_dat_r [2];
  logic [NS-1:0]     late_ack [2];
  int                s_cnt [2][NS];
  int                s_lat [NS];
  logic [1:0]        s_kind [NS];
  logic [31:0]       s_base [NS];

  logic [33:0] exp_q[$];
  int n_checks;
  int n_fail;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_mux_tmo #(
    .NUM_SLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(M_ADDR), .MATCH_MASK(M_MASK),
    .TIMEOUT(TMO), .REG_RESP(1'b0)
  ) u_dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr[0]), .wbm_dat_i(m_dat[0]), .wbm_sel_i(m_sel[0]), .wbm_we_i(m_we[0]),
    .wbm_cyc_i(m_cyc[0]), .wbm_stb_i(m_stb[0]), .wbm_cti_i(m_cti[0]), .wbm_bte_i(m_bte[0]),
    .wbm_dat_o(mo_dat[0]), .wbm_ack_o(mo_ack[0]), .wbm_err_o(mo_err[0]), .wbm_rty_o(mo_rty[0]),
    .wbs_adr_o(sb_adr[0]), .wbs_dat_o(sb_dat[0]), .wbs_sel_o(sb_sel[0]), .wbs_we_o(sb_we[0]),
    .wbs_cyc_o(sc_cyc[0]), .wbs_stb_o(sc_stb[0]), .wbs_cti_o(sb_cti[0]), .wbs_bte_o(sb_bte[0]),
    .wbs_dat_i(s_dat_r[0]), .wbs_ack_i(s_ack_r[0] | late_ack[0]), .wbs_err_i(s_err_r[0]),
    .wbs_rty_i(s_rty_r[0]), .tmo_o(tmo[0]), .tmo_slave_o(tmo_sl[0]), .dbg_state_o(dbg[0])
  );

  wb_mux_tmo #(
    .NUM_SLAVES(NS), .AW(AW), .DW(DW), .MATCH_ADDR(M_ADDR), .MATCH_MASK(M_MASK),
    .TIMEOUT(TMO), .REG_RESP(1'b1)
  ) u_dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr[1]), .wbm_dat_i(m_dat[1]), .wbm_sel_i(m_sel[1]), .wbm_we_i(m_we[1]),
    .wbm_cyc_i(m_cyc[1]), .wbm_stb_i(m_stb[1]), .wbm_cti_i(m_cti[1]), .wbm_bte_i(m_bte[1]),
    .wbm_dat_o(mo_dat[1]), .wbm_ack_o(mo_ack[1]), .wbm_err_o(mo_err[1]), .wbm_rty_o(mo_rty[1]),
    .wbs_adr_o(sb_adr[1]), .wbs_dat_o(sb_dat[1]), .wbs_sel_o(sb_sel[1]), .wbs_we_o(sb_we[1]),
    .wbs_cyc_o(sc_cyc[1]), .wbs_stb_o(sc_stb[1]), .wbs_cti_o(sb_cti[1]), .wbs_bte_o(sb_bte[1]),
    .wbs_dat_i(s_dat_r[1]), .wbs_ack_i(s_ack_r[1] | late_ack[1]), .wbs_err_i(s_err_r[1]),
    .wbs_rty_i(s_rty_r[1]), .tmo_o(tmo[1]), .tmo_slave_o(tmo_sl[1]), .dbg_state_o(dbg[1])
  );

  // Slave models: respond s_lat cycles after seeing cyc&stb (0 = never), one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        s_ack_r[d] <= '0;
        s_err_r[d] <= '0;
        s_rty_r[d] <= '0;
        s_dat_r[d] <= '0;
        for (int i = 0; i < NS; i++) s_cnt[d][i] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NS; i++) begin
          s_ack_r[d][i] <= 1'b0;
          s_err_r[d][i] <= 1'b0;
          s_rty_r[d][i] <= 1'b0;
          if (sc_cyc[d][i] && sc_stb[d][i] && !(s_ack_r[d][i] || s_err_r[d][i] || s_rty_r[d][i])) begin
            if (s_lat[i] != 0 && s_cnt[d][i] >= s_lat[i] - 1) begin
              s_cnt[d][i] <= 0;
              s_dat_r[d][i*DW +: DW] <= s_base[i] ^ sb_adr[d][i*AW +: AW];
              case (s_kind[i])
                K_ERR:   s_err_r[d][i] <= 1'b1;
                K_RTY:   s_rty_r[d][i] <= 1'b1;
                default: s_ack_r[d][i] <= 1'b1;
              endcase
            end else begin
              s_cnt[d][i] <= s_cnt[d][i] + 1;
            end
          end else begin
            s_cnt[d][i] <= 0;
          end
        end
      end
    end
  end

  // Driver: nbeats transfers under one cyc; each beat pushes its expectation and
  // pops it when the master sees a response. Also watches slave steering/broadcast.
  task automatic xfer(input int d, input logic [31:0] adr0, input int nbeats, input int exp_slave,
                      input logic [1:0] exp_kind, input bit zero_dat, input int lat0, input int latn,
                      output logic tmo_at, output logic [NS-1:0] cyc_at);
    logic [31:0] adr;
    logic [33:0] got;
    logic [33:0] exp;
    logic [NS-1:0] sel_mask;
    int n;
    bit seen;
    bit stray;
    bit saw_sel;
    adr = adr0;
    stray = 1'b0;
    saw_sel = 1'b0;
    tmo_at = 1'b0;
    cyc_at = '0;
    sel_mask = '0;
    if (exp_slave >= 0) sel_mask[exp_slave] = 1'b1;
    @(posedge clk); #1;
    m_adr[d] = adr;
    m_dat[d] = $urandom;
    m_sel[d] = 4'($urandom_range(0, 15));
    m_bte[d] = 2'($urandom_range(0, 3));
    m_we[d]  = 1'b0;
    m_cti[d] = (nbeats > 1) ? 3'b010 : 3'b000;
    m_cyc[d] = 1'b1;
    m_stb[d] = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      if (zero_dat) exp = {exp_kind, 32'h0};
      else          exp = {exp_kind, s_base[exp_slave] ^ adr};
      exp_q.push_back(exp);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
          if (sb_adr[d][i*AW +: AW] !== m_adr[d] || sb_dat[d][i*DW +: DW] !== m_dat[d] ||
              sb_sel[d][i*4 +: 4] !== m_sel[d] || sb_we[d][i] !== m_we[d] ||
              sb_cti[d][i*3 +: 3] !== m_cti[d] || sb_bte[d][i*2 +: 2] !== m_bte[d]) stray = 1'b1;
        end
        if ((sc_cyc[d] & ~sel_mask) !== '0 || (sc_stb[d] & ~sel_mask) !== '0) stray = 1'b1;
        if ((sc_stb[d] & sel_mask) !== '0) saw_sel = 1'b1;
        if (mo_ack[d] || mo_err[d] || mo_rty[d]) begin
          seen = 1'b1;
          tmo_at = tmo[d];
          cyc_at = sc_cyc[d];
        end else begin
          n++;
        end
      end
      got = {mo_err[d] | mo_rty[d], mo_ack[d] | mo_rty[d], mo_dat[d]};
      exp = exp_q.pop_front();
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL resp_wait dut%0d beat%0d: no response within 40 cycles, required kind %b", d, b, exp[33:32]);
      end else if (got !== exp) begin
        n_fail++;
        $display("FAIL resp dut%0d beat%0d adr %h: got kind %b dat %h, required kind %b dat %h",
                 d, b, adr, got[33:32], got[31:0], exp[33:32], exp[31:0]);
      end
      n_checks++;
      if (n !== ((b == 0) ? lat0 : latn)) begin
        n_fail++;
        $display("FAIL latency dut%0d beat%0d: got %0d cycles, required %0d", d, b, n, (b == 0) ? lat0 : latn);
      end
      @(posedge clk); #1;
      if (b == nbeats - 1) begin
        m_cyc[d] = 1'b0;
        m_stb[d] = 1'b0;
        m_cti[d] = 3'b000;
      end else begin
        adr = adr + 32'd4;
        m_adr[d] = adr;
        if (b == nbeats - 2) m_cti[d] = 3'b111;
      end
    end
    n_checks++;
    if (stray || (exp_slave >= 0 && !saw_sel)) begin
      n_fail++;
      $display("FAIL steering dut%0d: stray/broadcast error %0d, selected slave %0d strobed %0d, required 0/1",
               d, stray, exp_slave, saw_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({sc_cyc[d], sc_stb[d], mo_ack[d], mo_err[d], mo_rty[d], mo_dat[d], tmo[d], tmo_sl[d], dbg[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: cyc %b stb %b ack %b err %b rty %b dat %h tmo %b tmo_slave %0d state %0d, required all 0",
                 d, sc_cyc[d], sc_stb[d], mo_ack[d], mo_err[d], mo_rty[d], mo_dat[d], tmo[d], tmo_sl[d], dbg[d]);
      end
    end
  endtask

  task automatic test_read();
    logic t;
    logic [NS-1:0] c;
    xfer(0, 32'h0000_1040, 1, 2, K_ACK, 1'b0, 4, 4, t, c);
    xfer(1, 32'h0000_1040, 1, 2, K_ACK, 1'b0, 5, 5, t, c);
    xfer(0, 32'h0000_1140, 1, 1, K_ACK, 1'b0, 2, 2, t, c);
    xfer(0, 32'h0000_0000 | 32'($urandom_range(0, 1023) * 4), 1, 0, K_ACK, 1'b0, 3, 3, t, c);
  endtask

  task automatic test_unmapped();
    logic t;
    logic [NS-1:0] c;
    for (int d = 0; d < 2; d++) xfer(d, 32'h0000_3000, 1, -1, K_ERR, 1'b1, 1, 1, t, c);
  endtask

  task automatic test_resp_kinds();
    logic t;
    logic [NS-1:0] c;
    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'h0000_2010, 1, 3, K_RTY, 1'b0, 2 + d, 2 + d, t, c);
      xfer(d, 32'h0000_4020, 1, 4, K_ERR, 1'b0, 3 + d, 3 + d, t, c);
    end
  endtask

  task automatic test_timeout();
    logic t;
    logic [NS-1:0] c;
    xfer(0, 32'h0000_5000, 1, 5, K_ERR, 1'b1, TMO + 1, TMO + 1, t, c);
    n_checks++;
    if (t !== 1'b1 || c !== '0) begin
      n_fail++;
      $display("FAIL abort_flags: tmo_o %b wbs_cyc_o %b, required 1 and 0", t, c);
    end
    for (int k = 0; k < 3; k++) begin
      late_ack[0][5] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mo_ack[0] !== 1'b0 || tmo[0] !== 1'b0 || tmo_sl[0] !== 4'd5) begin
        n_fail++;
        $display("FAIL late_ack cycle%0d: ack %b tmo %b tmo_slave %0d, required 0 0 5", k, mo_ack[0], tmo[0], tmo_sl[0]);
      end
    end
    late_ack[0] = '0;
  endtask

  task automatic test_timeout_edge();
    logic t;
    logic [NS-1:0] c;
    xfer(0, 32'h0000_6000, 1, 6, K_ACK, 1'b0, TMO, TMO, t, c);
    n_checks++;
    if (t !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_ack_tmo dut0: tmo_o %b, required 0", t);
    end
    xfer(1, 32'h0000_6000, 1, 6, K_ACK, 1'b0, TMO + 1, TMO + 1, t, c);
    n_checks++;
    if (t !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_ack_tmo dut1: tmo_o %b, required 0", t);
    end
    xfer(0, 32'h0000_7004, 1, 7, K_ERR, 1'b1, TMO + 1, TMO + 1, t, c);
    @(negedge clk);
    n_checks++;
    if (t !== 1'b1 || tmo_sl[0] !== 4'd7) begin
      n_fail++;
      $display("FAIL edge_abort: tmo_o %b tmo_slave %0d, required 1 and 7", t, tmo_sl[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic t;
    logic [NS-1:0] c;
    xfer(0, 32'h0000_0FF8, 4, 0, K_ACK, 1'b0, 3, 2, t, c);
    xfer(1, 32'h0000_0FF8, 4, 0, K_ACK, 1'b0, 4, 3, t, c);
  endtask

  task automatic test_reset_mid();
    logic t;
    logic [NS-1:0] c;
    @(posedge clk); #1;
    m_adr[0] = 32'h0000_5010;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (sc_stb[0] !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL mid_active: wbs_stb_o %b, required 00100000", sc_stb[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sc_cyc[0], sc_stb[0], mo_ack[0], mo_err[0], tmo[0], dbg[0]} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: cyc %b stb %b ack %b err %b tmo %b state %0d, required all 0",
               sc_cyc[0], sc_stb[0], mo_ack[0], mo_err[0], tmo[0], dbg[0]);
    end
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(0, 32'h0000_1080, 1, 2, K_ACK, 1'b0, 4, 4, t, c);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_we[d] = 1'b0;
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_cti[d] = '0; m_bte[d] = '0;
      late_ack[d] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      s_base[i] = 32'hA000_0000 | (32'(i) << 16);
      s_kind[i] = K_ACK;
    end
    s_base[2] = 32'hDEAD_BEEF ^ 32'h0000_1040;
    s_lat[0] = 2;
    s_lat[1] = 1;
    s_lat[2] = 3;
    s_lat[3] = 1;  s_kind[3] = K_RTY;
    s_lat[4] = 2;  s_kind[4] = K_ERR;
    s_lat[5] = 0;
    s_lat[6] = TMO - 1;
    s_lat[7] = TMO;

    test_reset();
    test_read();
    test_unmapped();
    test_resp_kinds();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
